// File: rtl/jtbubl_gfx_romarb_pkg.sv
// Shared types for the graphics ROM arbiter: FSM state type and sizing constants.
package jtbubl_gfx_romarb_pkg;
  `include "jtbubl_gfx_romarb.vh"

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_ISSUE = ISSUE,
    ST_WAIT  = WAIT
  } state_t;

  localparam int NRQ   = 2;
  localparam int CNT_W = 8;
endpackage

// File: rtl/jtbubl_gfx_romarb.vh
// FSM state encodings for the graphics ROM arbiter.
`ifndef JTBUBL_GFX_ROMARB_VH
`define JTBUBL_GFX_ROMARB_VH
localparam logic [1:0] IDLE  = 2'd0;
localparam logic [1:0] ISSUE = 2'd1;
localparam logic [1:0] WAIT  = 2'd2;
`endif

// File: rtl/jtbubl_rr_pick.sv
// Two-way round-robin picker: a lone requester always wins, on a tie the one
// that was not served last wins.
module jtbubl_rr_pick (
  input  logic [1:0] pend_i,
  input  logic       last_i,
  output logic       gnt_o,
  output logic       gnt_vld_o
);
  always_comb begin
    gnt_vld_o = |pend_i;
    gnt_o     = pend_i[1];
    if (&pend_i) gnt_o = ~last_i;
  end
endmodule

// File: rtl/jtbubl_gfx_romarb.sv
// Shares one graphics SDRAM ROM port between the tile fetcher (0) and the
// object line-buffer filler (1), with per-requester one-entry result cache.
module jtbubl_gfx_romarb
  import jtbubl_gfx_romarb_pkg::*;
#(
  parameter int AW  = 18,
  parameter int DW  = 32,
  parameter int TMO = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rq0_cs,
  input  logic [AW-1:0] rq0_addr,
  output logic [DW-1:0] rq0_data,
  output logic          rq0_ok,
  input  logic          rq1_cs,
  input  logic [AW-1:0] rq1_addr,
  output logic [DW-1:0] rq1_data,
  output logic          rq1_ok,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  input  logic          rom_ok,
  output logic          busy,
  output logic          tmo_err
);
  localparam logic             TMO_EN  = (TMO != 0);
  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TMO - 1);

  state_t             state_q, state_d;
  logic               gnt_q, gnt_d;
  logic               rr_q, rr_d;
  logic               rom_cs_q, rom_cs_d;
  logic [AW-1:0]      rom_addr_q, rom_addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tmo_q, tmo_d;
  logic               cap;
  logic               abort;

  logic [NRQ-1:0]     cs_w, ok_w, pend_w;
  logic [AW-1:0]      addr_w [NRQ];
  logic [DW-1:0]      data_w [NRQ];
  logic               pick_gnt, pick_vld;

  assign cs_w      = {rq1_cs, rq0_cs};
  assign addr_w[0] = rq0_addr;
  assign addr_w[1] = rq1_addr;
  assign pend_w    = cs_w & ~ok_w;

  jtbubl_rr_pick u_pick (
    .pend_i    (pend_w),
    .last_i    (rr_q),
    .gnt_o     (pick_gnt),
    .gnt_vld_o (pick_vld)
  );

  // The granted requester withdrawing or moving its address invalidates the access.
  assign abort = ~cs_w[gnt_q] | (addr_w[gnt_q] != rom_addr_q);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_d       = rr_q;
    rom_cs_d   = rom_cs_q;
    rom_addr_d = rom_addr_q;
    cnt_d      = cnt_q;
    tmo_d      = 1'b0;
    cap        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          gnt_d      = pick_gnt;
          rom_addr_d = addr_w[pick_gnt];
          rom_cs_d   = 1'b1;
          cnt_d      = '0;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // rom_ok may still refer to the previous address here, so it is ignored.
        if (abort) begin
          rom_cs_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          rom_cs_d = 1'b0;
          state_d  = ST_IDLE;
        end else if (rom_ok) begin
          cap      = 1'b1;
          rom_cs_d = 1'b0;
          rr_d     = gnt_q;
          state_d  = ST_IDLE;
        end else if (TMO_EN && cnt_q == TMO_LIM) begin
          tmo_d    = 1'b1;
          rom_cs_d = 1'b0;
          rr_d     = gnt_q;
          state_d  = ST_IDLE;
        end else if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        rom_cs_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 1'b0;
      rr_q       <= 1'b1;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
      cnt_q      <= '0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_q       <= rr_d;
      rom_cs_q   <= rom_cs_d;
      rom_addr_q <= rom_addr_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
    end
  end

  for (genvar n = 0; n < NRQ; n++) begin : g_ret
    logic          vld_q;
    logic [AW-1:0] srv_q;
    logic [DW-1:0] dat_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        srv_q <= '0;
        dat_q <= '0;
      end else if (cap && gnt_q == 1'(n)) begin
        vld_q <= 1'b1;
        srv_q <= rom_addr_q;
        dat_q <= rom_data;
      end
    end

    assign ok_w[n]   = vld_q & cs_w[n] & (addr_w[n] == srv_q);
    assign data_w[n] = dat_q;
  end

  assign rq0_ok   = ok_w[0];
  assign rq1_ok   = ok_w[1];
  assign rq0_data = data_w[0];
  assign rq1_data = data_w[1];
  assign rom_cs   = rom_cs_q;
  assign rom_addr = rom_addr_q;
  assign busy     = (state_q != ST_IDLE);
  assign tmo_err  = tmo_q;
endmodule
